// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc register bank family.
// Provides the default data/address widths and the matching bus typedefs.
package nrisc_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/banco_regs_scoreboard.sv
// Per-register pending scoreboard.
// A reservation marks a register as awaiting a multicycle producer; the next
// write to that register clears it. A reservation wins over a write to the
// same register in the same cycle.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   wr_en, wr_addr    : writeback write (clears pending)
//   rsv_en, rsv_addr  : decode reservation (sets pending)
//   pend_vec          : pending bits, bit i = register i
module banco_regs_scoreboard #(
    parameter int unsigned ADDR_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic [(1 << ADDR_W)-1:0]    pend_vec
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Set has priority over clear; untouched bits hold.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

endmodule

// File: rtl/banco_regs_param.sv
// Parametrised nRisc register bank with pending scoreboard.
// Two combinational read ports, one synchronous write port, synchronous
// active-high reset clearing data and pending bits.
// Optional macro BANCO_REGS_BYPASS_EN: forwards a same-cycle write to the
// read ports (pending reads as 0 unless the same register is also reserved).
// Ports:
//   clock, reset                  : clock and synchronous active-high reset
//   rd_addr1/2 -> rd_data1/2      : asynchronous read data
//   rd_pend1/2                    : pending flag of the addressed register
//   wr_en, wr_addr, wr_data       : writeback port
//   rsv_en, rsv_addr              : reservation request from decode
//   pend_vec                      : all pending bits
module banco_regs_param
    import nrisc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           rd_addr1,
    input  logic [ADDR_W-1:0]           rd_addr2,
    output logic [DATA_W-1:0]           rd_data1,
    output logic [DATA_W-1:0]           rd_data2,
    output logic                        rd_pend1,
    output logic                        rd_pend2,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic [(1 << ADDR_W)-1:0]    pend_vec
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next-state of the data array: single write port.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    banco_regs_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend_vec (pend_vec)
    );

    // Read ports.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
        rd_pend1 = pend_vec[rd_addr1];
        rd_pend2 = pend_vec[rd_addr2];
`ifdef BANCO_REGS_BYPASS_EN
        // A same-cycle reservation keeps the register pending even when forwarded.
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_pend1 = rsv_en && (rsv_addr == rd_addr1);
        end
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_pend2 = rsv_en && (rsv_addr == rd_addr2);
        end
`endif
    end

endmodule

// File: tb/tb_banco_regs_param.sv
// Self-checking bench for banco_regs_param: directed scenarios plus random
// traffic, all checked against a behavioural model through an expected queue.
module tb_banco_regs_param;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0]   d1;
        logic [DATA_W-1:0]   d2;
        logic                p1;
        logic                p2;
        logic [NUM_REGS-1:0] pv;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [DATA_W-1:0]   rd_data1, rd_data2, wr_data;
    logic                rd_pend1, rd_pend2, wr_en, rsv_en;
    logic [NUM_REGS-1:0] pend_vec;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0]   m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_pend;
    exp_t                exp_q [$];

    // Values sampled in the most recent cycle.
    logic [DATA_W-1:0]   s_d1, s_d2;
    logic                s_p1, s_p2;
    logic [NUM_REGS-1:0] s_pv;

    always #5 clock = ~clock;

    banco_regs_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_pend1 (rd_pend1),
        .rd_pend2 (rd_pend2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend_vec (pend_vec)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, predict, compare mid-cycle, then advance model at the edge.
    task automatic cycle(input logic rst, input logic we, input int wa, input int wd,
                         input logic re, input int ra, input int a1, input int a2);
        exp_t e;
        exp_t g;
        @(negedge clock);
        reset    = rst;
        wr_en    = we;
        wr_addr  = ADDR_W'(wa);
        wr_data  = DATA_W'(wd);
        rsv_en   = re;
        rsv_addr = ADDR_W'(ra);
        rd_addr1 = ADDR_W'(a1);
        rd_addr2 = ADDR_W'(a2);

        e.d1 = m_regs[rd_addr1];
        e.d2 = m_regs[rd_addr2];
        e.p1 = m_pend[rd_addr1];
        e.p2 = m_pend[rd_addr2];
        e.pv = m_pend;
`ifdef BANCO_REGS_BYPASS_EN
        if (we && (wr_addr == rd_addr1)) begin
            e.d1 = wr_data;
            e.p1 = re && (rsv_addr == rd_addr1);
        end
        if (we && (wr_addr == rd_addr2)) begin
            e.d2 = wr_data;
            e.p2 = re && (rsv_addr == rd_addr2);
        end
`endif
        exp_q.push_back(e);

        #1;
        s_d1 = rd_data1;
        s_d2 = rd_data2;
        s_p1 = rd_pend1;
        s_p2 = rd_pend2;
        s_pv = pend_vec;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 64'd1, 64'd0);
        end else begin
            g = exp_q.pop_front();
            check_eq("rd_data1", 64'(s_d1), 64'(g.d1));
            check_eq("rd_data2", 64'(s_d2), 64'(g.d2));
            check_eq("rd_pend1", 64'(s_p1), 64'(g.p1));
            check_eq("rd_pend2", 64'(s_p2), 64'(g.p2));
            check_eq("pend_vec", 64'(s_pv), 64'(g.pv));
        end

        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = '0;
            m_pend = '0;
        end else begin
            if (we) m_regs[wr_addr] = wr_data;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (re && (rsv_addr == ADDR_W'(i)))     m_pend[i] = 1'b1;
                else if (we && (wr_addr == ADDR_W'(i))) m_pend[i] = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = '0;
        m_pend = '0;

        // Initial reset; the model is already clear so the second cycle is checkable.
        @(posedge clock);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset clears previously written data.
        cycle(0, 1, 2, 'hA5, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 2, 2);
        check_eq("pre_rst_reg2", 64'(s_d1), 64'hA5);
        cycle(1, 0, 0, 0, 0, 0, 2, 2);
        for (int a = 0; a < int'(NUM_REGS); a++) begin
            cycle(0, 0, 0, 0, 0, 0, a, a);
            check_eq("rst_data", 64'(s_d1), 64'h0);
            check_eq("rst_pend", 64'(s_pv), 64'h0);
        end

        // Write then read; write-cycle read returns old value without forwarding.
        cycle(0, 1, 1, 'h01, 0, 0, 1, 3);
`ifdef BANCO_REGS_BYPASS_EN
        check_eq("wcyc_fwd", 64'(s_d1), 64'h01);
`else
        check_eq("wcyc_old", 64'(s_d1), 64'h00);
`endif
        cycle(0, 1, 3, 'hFF, 0, 0, 1, 3);
        cycle(0, 0, 0, 0, 0, 0, 1, 3);
        check_eq("wr_rd1", 64'(s_d1), 64'h01);
        check_eq("wr_rd2", 64'(s_d2), 64'(DATA_W'('hFF)));

        // Reserve then clear by write.
        cycle(0, 0, 0, 0, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 2, 0);
        check_eq("rsv_vec", 64'(s_pv), 64'h4);
        check_eq("rsv_pend1", 64'(s_p1), 64'h1);
        cycle(0, 1, 2, 'h3C, 0, 0, 2, 0);
        cycle(0, 0, 0, 0, 0, 0, 2, 0);
        check_eq("clr_vec", 64'(s_pv), 64'h0);
        check_eq("clr_data", 64'(s_d1), 64'h3C);

        // Reservation beats a simultaneous write; data still lands.
        cycle(0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 1, 1, 'h7E, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        check_eq("sim_data", 64'(s_d1), 64'h7E);
        check_eq("sim_pend", 64'(s_pv[1]), 64'h1);

        // Reset beats write and reservation.
        cycle(1, 1, 0, 'h55, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rstp_data", 64'(s_d1), 64'h0);
        check_eq("rstp_vec", 64'(s_pv), 64'h0);

        // Same-cycle write to a read address.
        cycle(0, 0, 0, 0, 1, 3, 0, 3);
        cycle(0, 1, 3, 'h9C, 0, 0, 0, 3);
`ifdef BANCO_REGS_BYPASS_EN
        check_eq("byp_data", 64'(s_d2), 64'h9C);
        check_eq("byp_pend", 64'(s_p2), 64'h0);
`else
        check_eq("nobyp_data", 64'(s_d2), 64'h0);
        check_eq("nobyp_pend", 64'(s_p2), 64'h1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(31) == 0), 1'($urandom_range(1)),
                  int'($urandom_range(NUM_REGS - 1)), int'($urandom),
                  ($urandom_range(3) == 0), int'($urandom_range(NUM_REGS - 1)),
                  int'($urandom_range(NUM_REGS - 1)), int'($urandom_range(NUM_REGS - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
